// File: rtl/r2mdc_pkg.sv
// Shared types for the R2MDC FFT pipeline (commutators, butterflies).
package r2mdc_pkg;
  localparam int DATA_W = 16;

  // Complex sample at the default datapath width.
  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

  // Commutator phase: FILL stores the first half-frame, PAIR emits pairs.
  typedef enum logic {FILL = 1'b0, PAIR = 1'b1} state_t;
endpackage

// File: rtl/r2mdc_delay_ram.sv
// Single-port synchronous delay RAM: one-cycle read, rdata holds between reads.
module r2mdc_delay_ram #(
  parameter int DEPTH = 8,
  parameter int W     = 32,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];

  // Write port: contents are never cleared, only overwritten.
  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wdata;
  end

  // Read register: reset to zero so the A outputs start clean; holds when idle.
  always_ff @(posedge clk) begin
    if (rst)            rdata <= '0;
    else if (en && !we) rdata <= mem[addr];
  end
endmodule

// File: rtl/r2mdc_input_commutator.sv
// R2MDC input commutator: pairs x[k] with x[k+N/2] for the first butterfly.
// Optional feature macro: R2MDC_CMT_SOP_EN (in_sop restarts the frame count).
module r2mdc_input_commutator
  import r2mdc_pkg::*;
#(
  parameter int N      = 16,
  parameter int DATA_W = r2mdc_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic [DATA_W-1:0] in_re,
  input  logic [DATA_W-1:0] in_im,
  output logic              out_valid,
  output logic              out_last,
  output logic [DATA_W-1:0] A_re,
  output logic [DATA_W-1:0] A_im,
  output logic [DATA_W-1:0] B_re,
  output logic [DATA_W-1:0] B_im
);
  localparam int CW   = $clog2(N);
  localparam int HALF = N / 2;
  localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CW-1:0]       cnt, cnt_eff;
  state_t              st, cur_st;
  logic                sop_hit;
  logic                pair_acc;
  logic [2*DATA_W-1:0] rdata;
  logic [DATA_W-1:0]   b_re_q, b_im_q;

`ifdef R2MDC_CMT_SOP_EN
  assign sop_hit = in_valid & in_sop;
`else
  logic unused_sop;
  assign unused_sop = in_sop;
  assign sop_hit    = 1'b0;
`endif

  // A start-of-frame sample is treated as count 0 (FILL) this very cycle.
  assign cnt_eff  = sop_hit ? '0 : cnt;
  assign cur_st   = sop_hit ? FILL : st;
  assign pair_acc = in_valid && (cur_st == PAIR);

  r2mdc_delay_ram #(.DEPTH(HALF), .W(2*DATA_W)) u_ram (
    .clk  (clk),
    .rst  (rst),
    .en   (in_valid),
    .we   (cur_st == FILL),
    .addr (cnt_eff[AW-1:0]),
    .wdata({in_re, in_im}),
    .rdata(rdata)
  );

  // Sample counter and phase FSM; everything holds while in_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      st  <= FILL;
    end else if (in_valid) begin
      cnt <= cnt_eff + 1'b1;
      case (cur_st)
        FILL: if (cnt_eff == CW'(HALF-1)) st <= PAIR;
        PAIR: if (cnt_eff == CW'(N-1))    st <= FILL;
        default: st <= FILL;
      endcase
    end
  end

  // B path registered once so it lines up with the RAM read of A.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      b_re_q    <= '0;
      b_im_q    <= '0;
    end else begin
      out_valid <= pair_acc;
      out_last  <= pair_acc && (cnt_eff == CW'(N-1));
      if (pair_acc) begin
        b_re_q <= in_re;
        b_im_q <= in_im;
      end
    end
  end

  assign A_re = rdata[2*DATA_W-1:DATA_W];
  assign A_im = rdata[DATA_W-1:0];
  assign B_re = b_re_q;
  assign B_im = b_im_q;
endmodule
